clk_div_bank: RTL

CLK_DIV_BANK -- requirements
Module: clk_div_bank

---
 rtl/clk_div_pkg.sv | 23 ++
 rtl/clk_div_chan.sv | 64 ++++++
 rtl/clk_div_bank.sv | 100 ++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock divider bank: FSM states and
// the divisor/phase clamping applied to every configuration write.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_LOCKED,
        ST_SETTLE
    } state_e;

    localparam logic [31:0] MIN_DIV = 32'd2;

    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

    // Expects an already clamped divisor, so div - 1 cannot underflow.
    function automatic logic [31:0] clamp_phase(input logic [31:0] phase,
                                                input logic [31:0] div);
        return (phase >= div) ? div - 32'd1 : phase;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow/active (div, phase) pairs, a period counter
// and registered outclk / outclk_stb derived from the counter.
module clk_div_chan #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] wr_phase,
    input  logic             realign,
    output logic             outclk,
    output logic             outclk_stb
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] sh_div, sh_phase, act_div, act_phase, cnt;
    logic [DIV_W-1:0] sh_div_n, sh_phase_n, act_div_n, act_phase_n, cnt_n;
    logic             wrap;

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        sh_div_n    = sh_div;
        sh_phase_n  = sh_phase;
        act_div_n   = act_div;
        act_phase_n = act_phase;
        wrap        = (act_div <= DIV_W'(1)) || (cnt >= act_div - DIV_W'(1));
        cnt_n       = wrap ? '0 : cnt + DIV_W'(1);
        if (wr_en) begin
            sh_div_n   = wr_div;
            sh_phase_n = wr_phase;
        end
        if (realign) begin
            act_div_n   = sh_div;
            act_phase_n = sh_phase;
            cnt_n       = sh_phase;
        end
    end

    // NOTE: outputs are registered from the next-state values so that in any
    // cycle they describe the counter value held in that same cycle.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sh_div     <= RST_DIV;
            sh_phase   <= '0;
            act_div    <= RST_DIV;
            act_phase  <= '0;
            cnt        <= '0;
            outclk     <= (RST_DIV >> 1) != '0;
            outclk_stb <= 1'b1;
        end else begin
            sh_div     <= sh_div_n;
            sh_phase   <= sh_phase_n;
            act_div    <= act_div_n;
            act_phase  <= act_phase_n;
            cnt        <= cnt_n;
            outclk     <= cnt_n < (act_div_n >> 1);
            outclk_stb <= cnt_n == '0;
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers with batched, atomically
// committed configuration and a lock indicator after realignment.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 5,
    parameter int LOCK_DELAY  = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic              cfg_last,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] outclk_stb,
    output logic              locked
);

    state_e             state, state_n;
    logic [7:0]         settle_cnt, settle_n;
    logic               commit_pend, commit_n;
    logic               accept, ch_ok;
    logic [DIV_W-1:0]   eff_div, eff_phase;
    logic [NUM_CH-1:0]  wr_en;

    // A commit is held for one cycle so the realign edge also blocks new writes.
    assign cfg_ready = (state == ST_LOCKED) && !commit_pend;
    assign locked    = (state == ST_LOCKED);
    assign accept    = cfg_valid && cfg_ready;
    assign ch_ok     = int'(cfg_ch) < NUM_CH;
    assign eff_div   = DIV_W'(clamp_div(32'(cfg_div)));
    assign eff_phase = DIV_W'(clamp_phase(32'(cfg_phase), 32'(eff_div)));

    always_comb begin
        state_n  = state;
        settle_n = settle_cnt;
        commit_n = commit_pend;
        case (state)
            ST_INIT, ST_SETTLE: begin
                if (settle_cnt == 8'(LOCK_DELAY - 1)) begin
                    state_n  = ST_LOCKED;
                    settle_n = '0;
                end else begin
                    settle_n = settle_cnt + 8'd1;
                end
            end
            ST_LOCKED: begin
                if (commit_pend) begin
                    state_n  = ST_SETTLE;
                    settle_n = '0;
                    commit_n = 1'b0;
                end else if (accept && cfg_last) begin
                    commit_n = 1'b1;
                end
            end
            default: state_n = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= ST_INIT;
            settle_cnt  <= '0;
            commit_pend <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= state_n;
            settle_cnt  <= settle_n;
            commit_pend <= commit_n;
            cfg_err     <= accept && !ch_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_en[i] = accept && ch_ok && (cfg_ch == CH_W'(i));

        clk_div_chan #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_chan (
            .refclk    (refclk),
            .rst       (rst),
            .wr_en     (wr_en[i]),
            .wr_div    (eff_div),
            .wr_phase  (eff_phase),
            .realign   (commit_pend),
            .outclk    (outclk[i]),
            .outclk_stb(outclk_stb[i])
        );
    end

endmodule
